// File: rtl/uart_rx_core_pkg.sv
// Shared UART receiver definitions: FSM states, configuration codes and small helpers.
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    localparam logic DBITS_7 = 1'b0;
    localparam logic DBITS_8 = 1'b1;

    // Code 11 is treated as "no parity" alongside 00.
    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

    // Last tick index of the STOP state for a given stop-bit code.
    function automatic int unsigned stop_last_tick(input logic [1:0] stop, input int unsigned ovs);
        case (stop)
            STOP_1:   return ovs - 1;
            STOP_1P5: return (3 * ovs) / 2 - 1;
            STOP_2:   return 2 * ovs - 1;
            default:  return ovs - 1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx line synchronizer (preset to idle-high) with falling-edge detect on the synchronized line.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall_c = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start validation, 7/8 data bits, optional parity, 1/1.5/2 stop bits.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tick,
    input  logic       rx,
    input  logic       cfg_dbits,
    input  logic [1:0] cfg_parity,
    input  logic [1:0] cfg_stop,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = $clog2(2 * OVS);
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(OVS - 1);
    localparam logic [TW-1:0] T_2BIT = TW'(2 * OVS - 1);

    logic            rx_s;
    logic            fall_c;
    rx_state_e       state;
    logic [TW-1:0]   t;
    logic [2:0]      n;
    logic [7:0]      shreg;
    logic            dbits_q;
    logic [1:0]      par_q;
    logic [1:0]      stop_q;
    logic            perr_q;
    logic            ferr_q;

    logic [TW-1:0]   stop_end_c;
    logic [2:0]      n_last_c;
    logic            par_bad_c;
    logic            stop_low_c;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall_c(fall_c)
    );

    // Frame-shape decodes from the shadowed configuration.
    always_comb begin
        stop_end_c = TW'(stop_last_tick(stop_q, OVS));
        n_last_c   = (dbits_q == DBITS_7) ? 3'd6 : 3'd7;
        par_bad_c  = (par_q == PAR_EVEN) ? (^shreg ^ rx_s) : ~(^shreg ^ rx_s);
        stop_low_c = s_tick && (state == ST_STOP) && !rx_s &&
                     ((t == T_BIT) || ((stop_q == STOP_2) && (t == T_2BIT)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            t            <= '0;
            n            <= '0;
            shreg        <= '0;
            dbits_q      <= DBITS_8;
            par_q        <= PAR_NONE;
            stop_q       <= STOP_1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (fall_c) begin
                        state   <= ST_START;
                        busy    <= 1'b1;
                        t       <= '0;
                        dbits_q <= cfg_dbits;
                        par_q   <= cfg_parity;
                        stop_q  <= cfg_stop;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (t == T_HALF) begin
                            t <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                                n     <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (t == T_BIT) begin
                            t <= '0;
                            if (n == n_last_c) begin
                                // 7-bit frames are right-justified so dout[7] reads 0.
                                shreg <= (dbits_q == DBITS_8) ? {rx_s, shreg[7:1]}
                                                              : {1'b0, rx_s, shreg[7:2]};
                                n     <= '0;
                                state <= par_enabled(par_q) ? ST_PARITY : ST_STOP;
                            end else begin
                                shreg <= {rx_s, shreg[7:1]};
                                n     <= n + 3'd1;
                            end
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (t == T_BIT) begin
                            perr_q <= par_bad_c;
                            t      <= '0;
                            state  <= ST_STOP;
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (stop_low_c) begin
                            ferr_q <= 1'b1;
                        end
                        if (t == stop_end_c) begin
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            t            <= '0;
                            rx_done_tick <= 1'b1;
                            dout         <= shreg;
                            parity_err   <= perr_q;
                            frame_err    <= ferr_q | stop_low_c;
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of frames plus glitch, break, reset and back-to-back sequences.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       cfg_dbits = 1'b1;
    logic [1:0] cfg_parity = 2'b00;
    logic [1:0] cfg_stop = 2'b00;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;

    uart_rx_core #(
        .OVS(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tick      (s_tick),
        .rx          (rx),
        .cfg_dbits   (cfg_dbits),
        .cfg_parity  (cfg_parity),
        .cfg_stop    (cfg_stop),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clocks.
    logic [1:0] tick_div = 2'd0;
    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        s_tick   <= (tick_div == 2'd3);
    end

    // Strobe monitor: counts strobes and captures the reported frame.
    int         done_cnt = 0;
    int         b2b_cnt = 0;
    int         busy_cnt = 0;
    logic       prev_done = 1'b0;
    logic [7:0] cap_dout = 8'h00;
    logic [7:0] cap_prev = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt <= done_cnt + 1;
            cap_prev <= cap_dout;
            cap_dout <= dout;
            cap_perr <= parity_err;
            cap_ferr <= frame_err;
            if (prev_done) b2b_cnt <= b2b_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        prev_done <= rx_done_tick;
    end

    typedef struct {
        logic       dbits;
        logic [1:0] par;
        logic [1:0] stop;
        logic [7:0] data;
        logic       flip;
        logic       s1_low;
        logic       s2_low;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic val, input int n);
        rx = val;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; config is scrambled after the start bit to prove it was shadowed.
    task automatic send_frame(input vec_t v, input int lead);
        int   nb;
        logic pb;
        nb = v.dbits ? 8 : 7;
        pb = 1'b0;
        for (int i = 0; i < nb; i++) pb ^= v.data[i];
        if (v.par == 2'b10) pb = ~pb;
        pb ^= v.flip;
        cfg_dbits  = v.dbits;
        cfg_parity = v.par;
        cfg_stop   = v.stop;
        if (lead > 0) drive_bit(1'b1, lead);
        drive_bit(1'b0, BIT_CLKS);
        check("busy_mid", 32'(busy), 32'd1);
        cfg_dbits  = ~v.dbits;
        cfg_parity = ~v.par;
        cfg_stop   = ~v.stop;
        for (int i = 0; i < nb; i++) drive_bit(v.data[i], BIT_CLKS);
        if (v.par == 2'b01 || v.par == 2'b10) drive_bit(pb, BIT_CLKS);
        case (v.stop)
            2'b01: drive_bit(~v.s1_low, BIT_CLKS + BIT_CLKS / 2);
            2'b10: begin
                drive_bit(~v.s1_low, BIT_CLKS);
                drive_bit(~v.s2_low, BIT_CLKS);
            end
            default: drive_bit(~v.s1_low, BIT_CLKS);
        endcase
        rx = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        base = done_cnt;
        send_frame(v, 8);
        drive_bit(1'b1, BIT_CLKS);
        check({tag, "_strobes"}, 32'(done_cnt - base), 32'd1);
        check({tag, "_dout"}, 32'(cap_dout), 32'(v.exp_dout));
        check({tag, "_perr"}, 32'(cap_perr), 32'(v.exp_perr));
        check({tag, "_ferr"}, 32'(cap_ferr), 32'(v.exp_ferr));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   base;
        int   bbase;
        vec_t v;

        //          dbits par    stop   data   flip s1l s2l  dout  perr ferr
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 8'h41, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 2'b00, 8'h41, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 2'b10, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 2'b10, 2'b10, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 2'b00, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 2'b00, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 2'b00, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 8'hD5, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b11, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 2'b10, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(rx_done_tick), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        drive_bit(1'b1, BIT_CLKS);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Short low glitch on an idle line: busy pulses, no frame
        cfg_dbits = 1'b1; cfg_parity = 2'b00; cfg_stop = 2'b00;
        base  = done_cnt;
        bbase = busy_cnt;
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 3 * BIT_CLKS);
        check("glitch_strobes", 32'(done_cnt - base), 32'd0);
        check("glitch_busy_seen", 32'(busy_cnt > bbase), 32'd1);
        check("glitch_busy_after", 32'(busy), 32'd0);
        check("glitch_dout_hold", 32'(dout), 32'h01);

        // Break: 20 bit times low gives exactly one errored frame
        base = done_cnt;
        drive_bit(1'b0, 20 * BIT_CLKS);
        check("break_strobes", 32'(done_cnt - base), 32'd1);
        check("break_dout", 32'(cap_dout), 32'h00);
        check("break_ferr", 32'(cap_ferr), 32'd1);
        check("break_perr", 32'(cap_perr), 32'd0);
        drive_bit(1'b1, BIT_CLKS);
        v = '{1'b1, 2'b00, 2'b00, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
        run_vec(v, "after_break");

        // Reset in the middle of the data bits of 0xFF
        cfg_dbits = 1'b1; cfg_parity = 2'b00; cfg_stop = 2'b00;
        base = done_cnt;
        drive_bit(1'b1, 8);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, 3 * BIT_CLKS);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dout", 32'(dout), 32'h00);
        rst_n = 1'b1;
        drive_bit(1'b1, 6 * BIT_CLKS);
        check("midrst_no_strobe", 32'(done_cnt - base), 32'd0);
        v = '{1'b1, 2'b00, 2'b00, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0};
        run_vec(v, "after_rst");

        // Back-to-back 8N1 frames with no idle gap
        base = done_cnt;
        v = '{1'b1, 2'b00, 2'b00, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
        send_frame(v, 8);
        v = '{1'b1, 2'b00, 2'b00, 8'hAA, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0};
        send_frame(v, 0);
        drive_bit(1'b1, BIT_CLKS);
        check("b2b_strobes", 32'(done_cnt - base), 32'd2);
        check("b2b_first", 32'(cap_prev), 32'h55);
        check("b2b_second", 32'(cap_dout), 32'hAA);
        check("b2b_ferr", 32'(cap_ferr), 32'd0);

        check("strobe_never_consecutive", 32'(b2b_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
